// File: rtl/io_walk_pkg.sv
// io_walk_pkg: shared state encoding, default sizes and pad pattern helper for the IO walk generator
package io_walk_pkg;

    localparam int IW_WIDTH  = 4;
    localparam int IW_HOLD_W = 16;

    typedef enum logic [1:0] {
        IW_IDLE,
        IW_WALK,
        IW_ALL_ON,
        IW_DONE
    } iw_state_t;

    // Pad pattern for a state/index pair; callers truncate the result to their own width
    function automatic logic [31:0] iw_pattern(
        input iw_state_t   state,
        input int unsigned idx,
        input int unsigned width
    );
        logic [31:0] ones;
        ones = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (state == IW_WALK) ? (32'd1 << idx) :
               (state == IW_ALL_ON || state == IW_DONE) ? ones : '0;
    endfunction

endpackage

// File: rtl/io_walk_hold_cnt.sv
// io_walk_hold_cnt: loadable hold counter that flags the last cycle of each pattern step
module io_walk_hold_cnt
    import io_walk_pkg::*;
#(
    parameter int HOLD_W = IW_HOLD_W
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              clear,
    input  logic              load,
    input  logic              en,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              expire
);

    logic [HOLD_W-1:0] hold_len;
    logic [HOLD_W-1:0] cnt;

    // Counts 1..H and compares for equality, so H = all ones never wraps
    assign expire = en && (cnt == hold_len);

    // Latch the effective hold (0 treated as 1) on load, then count while a step is active
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            hold_len <= '0;
            cnt      <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            hold_len <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
            cnt      <= HOLD_W'(1);
        end else if (en) begin
            cnt <= expire ? HOLD_W'(1) : cnt + HOLD_W'(1);
        end
    end

endmodule

// File: rtl/io_walk_pattern_gen.sv
// io_walk_pattern_gen: drives a walking-one then all-ones sequence onto a pad group
module io_walk_pattern_gen
    import io_walk_pkg::*;
#(
    parameter int WIDTH  = IW_WIDTH,
    parameter int HOLD_W = IW_HOLD_W
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic [WIDTH-1:0]  io_out,
    output logic [WIDTH-1:0]  io_oeb,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    iw_state_t        state;
    iw_state_t        state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             load;
    logic             clear;
    logic             expire;
    logic             last_idx;

    assign last_idx = (idx == IDX_W'(WIDTH - 1));

    io_walk_hold_cnt #(
        .HOLD_W(HOLD_W)
    ) u_hold_cnt (
        .clock      (clock),
        .resetb     (resetb),
        .clear      (clear),
        .load       (load),
        .en         (state == IW_WALK || state == IW_ALL_ON),
        .hold_cycles(hold_cycles),
        .expire     (expire)
    );

    // Next state and index; abort wins over everything, start only counts when not running
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        clear     = 1'b0;
        if (abort) begin
            state_nxt = IW_IDLE;
            idx_nxt   = '0;
            clear     = 1'b1;
        end else begin
            case (state)
                IW_IDLE, IW_DONE: begin
                    if (start) begin
                        state_nxt = IW_WALK;
                        idx_nxt   = '0;
                        load      = 1'b1;
                    end
                end
                IW_WALK: begin
                    if (expire) begin
                        state_nxt = last_idx ? IW_ALL_ON : IW_WALK;
                        idx_nxt   = last_idx ? '0 : idx + IDX_W'(1);
                    end
                end
                default: begin
                    if (expire) begin
                        state_nxt = loop_en ? IW_WALK : IW_DONE;
                        idx_nxt   = '0;
                    end
                end
            endcase
        end
    end

    // State and walk index registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= IW_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            io_out <= '0;
            io_oeb <= '1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            io_out <= WIDTH'(iw_pattern(state_nxt, 32'(idx_nxt), WIDTH));
            io_oeb <= load ? '0 : io_oeb;
            busy   <= (state_nxt == IW_WALK || state_nxt == IW_ALL_ON);
            done   <= (state_nxt == IW_DONE);
        end
    end

endmodule

// File: tb/tb_io_walk_pattern_gen.sv
// tb_io_walk_pattern_gen: randomized self-checking bench against an elapsed-time reference model
module tb_io_walk_pattern_gen;

    logic        clock = 1'b0;
    logic        resetb;
    logic        start;
    logic        abort;
    logic        loop_en;
    logic [15:0] hold_cycles;
    logic [3:0]  io_out;
    logic [3:0]  io_oeb;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 running, 2 done; t = cycles elapsed in the current pass
    int m_mode = 0;
    int m_t = 0;
    int m_h = 1;
    bit m_oe = 0;

    logic [9:0] got;
    logic [9:0] exp;

    io_walk_pattern_gen dut (
        .clock      (clock),
        .resetb     (resetb),
        .start      (start),
        .abort      (abort),
        .loop_en    (loop_en),
        .hold_cycles(hold_cycles),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Expected {io_out, io_oeb, busy, done}: pattern k = t / H, walking one for k < 4, else all ones
    function automatic logic [9:0] exp_vec();
        logic [3:0] o;
        int k;
        k = m_t / m_h;
        o = (m_mode == 1) ? ((k < 4) ? 4'(1 << k) : 4'hF) : (m_mode == 2) ? 4'hF : 4'h0;
        return {o, m_oe ? 4'h0 : 4'hF, m_mode == 1, m_mode == 2};
    endfunction

    task automatic step(input logic st, input logic ab, input logic lp, input logic [15:0] hc);
        start = st;
        abort = ab;
        loop_en = lp;
        hold_cycles = hc;
        @(posedge clock);
        if (ab) begin
            m_mode = 0;
            m_t = 0;
        end else if (m_mode != 1) begin
            if (st) begin
                m_mode = 1;
                m_t = 0;
                m_h = (hc == 0) ? 1 : int'(hc);
                m_oe = 1;
            end
        end else begin
            m_t++;
            if (m_t == 5 * m_h) begin
                if (lp) m_t = 0;
                else begin
                    m_mode = 2;
                    m_t = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        start = 0; abort = 0; loop_en = 0; hold_cycles = 0;
        repeat (2) @(posedge clock);
        #1;
        got = {io_out, io_oeb, busy, done};
        checks++;
        if (got !== 10'b0000_1111_0_0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", got, 10'b0000_1111_0_0);
        end
        #3 resetb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, $urandom_range(0, 1), 16'($urandom_range(0, 5)));
            got = {io_out, io_oeb, busy, done};
            exp = exp_vec();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_idle got=%b exp=%b", got, exp);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111};
        step(1, 0, 0, 16'd3);
        checks++;
        if (io_oeb !== 4'h0) begin
            failures++;
            $display("FAIL basic_oeb got=%b exp=%b", io_oeb, 4'h0);
        end
        for (int i = 0; i < 15; i++) begin
            got = {io_out, io_oeb, busy, done};
            exp = exp_vec();
            checks++;
            if (got !== exp || io_out !== seq[i / 3]) begin
                failures++;
                $display("FAIL basic_seq cycle=%0d got=%b exp=%b", i + 1, got, exp);
            end
            step(0, 0, 0, 16'($urandom_range(0, 9)));
        end
        checks++;
        if (done !== 1'b1 || io_out !== 4'hF || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done cycle=16 got done=%b out=%b busy=%b exp 1/1111/0", done, io_out, busy);
        end
    endtask

    task automatic test_zero_hold();
        step(1, 0, 0, 16'd0);
        for (int i = 0; i < 7; i++) begin
            got = {io_out, io_oeb, busy, done};
            exp = exp_vec();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL zero_hold cycle=%0d got=%b exp=%b", i + 1, got, exp);
            end
            step(0, 0, 0, 16'($urandom_range(1, 9)));
        end
    endtask

    task automatic test_loop();
        step(1, 0, 1, 16'd2);
        for (int i = 0; i < 24; i++) begin
            got = {io_out, io_oeb, busy, done};
            exp = exp_vec();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL loop cycle=%0d got=%b exp=%b", i + 1, got, exp);
            end
            if (i == 10 && io_out !== 4'b0001) begin
                failures++;
                $display("FAIL loop_wrap got=%b exp=%b", io_out, 4'b0001);
            end
            step(0, 0, (i < 12), 16'd7);
        end
        checks++;
        if (done !== 1'b1 || io_out !== 4'hF) begin
            failures++;
            $display("FAIL loop_end got done=%b out=%b exp 1/1111", done, io_out);
        end
    endtask

    task automatic test_abort();
        step(1, 0, 0, 16'd2);
        repeat (4) step(0, 0, 0, 16'd2);
        checks++;
        if (io_out !== 4'b0100) begin
            failures++;
            $display("FAIL abort_pre got=%b exp=%b", io_out, 4'b0100);
        end
        step(0, 1, 0, 16'd2);
        got = {io_out, io_oeb, busy, done};
        exp = exp_vec();
        checks++;
        if (got !== exp || got !== 10'b0000_0000_0_0) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=%b", got, exp);
        end
        step(1, 0, 0, 16'd1);
        got = {io_out, io_oeb, busy, done};
        exp = exp_vec();
        checks++;
        if (got !== exp || io_out !== 4'b0001) begin
            failures++;
            $display("FAIL abort_restart got=%b exp=%b", got, exp);
        end
        repeat (5) step(0, 0, 0, 16'd0);
    endtask

    task automatic test_start_ignored();
        step(1, 0, 0, 16'd2);
        for (int i = 0; i < 12; i++) begin
            got = {io_out, io_oeb, busy, done};
            exp = exp_vec();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL start_ignored cycle=%0d got=%b exp=%b", i + 1, got, exp);
            end
            step((i < 8) ? 1'(i % 2) : 1'b0, 0, 0, 16'd5);
        end
        step(1, 1, 0, 16'd2);
        got = {io_out, io_oeb, busy, done};
        exp = exp_vec();
        checks++;
        if (got !== exp || io_out !== 4'h0) begin
            failures++;
            $display("FAIL start_abort got=%b exp=%b", got, exp);
        end
        step(0, 0, 0, 16'd2);
        got = {io_out, io_oeb, busy, done};
        exp = exp_vec();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL start_abort_stay got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_max_hold();
        step(1, 0, 0, 16'hFFFF);
        repeat (20) step(0, 0, 0, 16'd1);
        got = {io_out, io_oeb, busy, done};
        exp = exp_vec();
        checks++;
        if (got !== exp || io_out !== 4'b0001) begin
            failures++;
            $display("FAIL max_hold got=%b exp=%b", got, exp);
        end
        step(0, 1, 0, 16'd1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                 1'($urandom_range(0, 1)), 16'($urandom_range(0, 3)));
            got = {io_out, io_oeb, busy, done};
            exp = exp_vec();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random cycle=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, 1, 0, 16'd0);
        step(1, 0, 0, 16'd3);
        repeat (10) step(0, 0, 0, 16'd3);
        checks++;
        if (io_out !== 4'b1000) begin
            failures++;
            $display("FAIL async_pre got=%b exp=%b", io_out, 4'b1000);
        end
        #3 resetb = 1'b0;
        #1;
        m_mode = 0;
        m_t = 0;
        m_oe = 0;
        got = {io_out, io_oeb, busy, done};
        checks++;
        if (got !== 10'b0000_1111_0_0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", got, 10'b0000_1111_0_0);
        end
        @(posedge clock);
        #3 resetb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 16'd3);
            got = {io_out, io_oeb, busy, done};
            exp = exp_vec();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL async_idle cycle=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_hold();
        test_loop();
        test_abort();
        test_start_ignored();
        test_max_hold();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_walk_pattern_gen.md
# io_walk_pattern_gen

User-project-area block that drives a walking-one pattern, then all-ones, onto a 4-bit group of `mprj_io` pads (`mprj_io[11:8]` at top level). It is the producing end of the chip-level IO-ports check, which waits for 0001, 0010, 0100, 1000, 1111 in that order. Firmware starts it through logic-analyzer or Wishbone-mapped control bits. The block owns both the pad output values and the pad output enables for its group.

## Interface
- `WIDTH`, 4, pad group width; the sequence has WIDTH+1 steps.
- `HOLD_W`, 16, width of the hold-count input.

- `clock`  in  1  system clock.
- `resetb`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request; acted on only in IDLE or DONE.
- `abort`  in  1  forces return to IDLE; priority over `start`.
- `loop_en`  in  1  when 1, the sequence repeats after the all-ones step.
- `hold_cycles`  in  HOLD_W  cycles each pattern is held; captured on accepted start.
- `io_out`  out  WIDTH  pad output values.
- `io_oeb`  out  WIDTH  pad output-enable bar; 0 means driven.
- `busy`  out  1  high while a sequence is running.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, WALK, ALL_ON, DONE.
- WALK carries index `idx` in 0..WIDTH-1 and drives `io_out = 1 << idx`. ALL_ON drives all ones.
- Effective hold H = `hold_cycles` if nonzero, otherwise 1. H is latched on accepted start and ignored mid-sequence.
- IDLE behaviour:
  - `io_out` = 0, `busy` = 0, `done` = 0.
  - On `start` (and no `abort`): latch H, go to WALK with idx=0.
- WALK behaviour:
  - After H cycles at idx, advance to idx+1.
  - After H cycles at idx=WIDTH-1, go to ALL_ON.
- ALL_ON behaviour:
  - After H cycles, if `loop_en`=1 (sampled on that final cycle), go to WALK idx=0.
  - Otherwise go to DONE.
- DONE behaviour:
  - `io_out` holds all ones, `done` = 1, `busy` = 0.
  - `start` restarts exactly as from IDLE, including a fresh H latch.
- `abort`, in any state: next cycle is IDLE with `io_out` = 0. The hold counter is cleared.
- `start` while in WALK or ALL_ON is ignored.
- `io_oeb`:
  - All ones from reset until the first accepted start.
  - All zeros from the first accepted start onward, in every state, including after abort.
  - Returns to all ones only on reset.
- `busy` = 1 exactly in WALK and ALL_ON.

## Timing
- Reset values: `io_out` = 0, `io_oeb` = all ones, `busy` = 0, `done` = 0, state IDLE, hold counter 0, idx 0. All outputs are registered.
- Start latency: `start` sampled high at edge N gives `io_out` = 0001, `busy` = 1, and `io_oeb` = 0 after edge N.
- Each pattern is visible for exactly H cycles, so a full pass is (WIDTH+1)·H cycles.
- Non-loop sequence: `done` rises at the same edge on which ALL_ON's H-th cycle ends. `io_out` does not glitch and stays all ones.
- Loop sequence: 1111 is followed directly by 0001, with no idle cycle between them.
- Hold counter width is HOLD_W. It counts 1..H and compares for equality, so it never wraps. H = 2^HOLD_W − 1 is legal.
- Simultaneous `start` and `abort` resolves to IDLE. `start` must be re-asserted afterwards.
- `resetb` asserted mid-sequence clears all outputs immediately (asynchronously) to their reset values, including `io_oeb`.

## Structure
- Package `io_walk_pkg` holds:
  - the state enum (`IW_IDLE`, `IW_WALK`, `IW_ALL_ON`, `IW_DONE`);
  - the default WIDTH and HOLD_W constants;
  - a function returning the pattern for a given state and idx.
- Sub-module `io_walk_hold_cnt` provides the loadable hold counter. It has load/clear inputs and a `expire` pulse output, with H=0→1 handled inside it.
- The top level contains the FSM, idx register, and output registers.

## Test plan
- Reset, then start with `hold_cycles`=3 and `loop_en`=0:
  - expected `io_out` = 0001, 0010, 0100, 1000, 1111, each held 3 cycles;
  - `done`=1 on cycle 16 after start;
  - `io_oeb` goes 1111 → 0000 one cycle after start.
- `hold_cycles`=0 → each pattern held 1 cycle; the sequence completes in 5 cycles.
- `loop_en`=1 with H=2 → after 1111 comes 0001 immediately. Clearing `loop_en` during the second pass ends in DONE with 1111 held.
- `abort` during the 0100 step → next cycle `io_out` = 0000, `busy` = 0, `io_oeb` stays 0000. A subsequent start restarts at 0001.
- `start` pulsed during WALK → ignored and the step timing is unchanged. Simultaneous `start` and `abort` in DONE → IDLE with `io_out` = 0000.
- Assert `resetb` low mid-1000 step, asynchronously between edges → outputs go to 0000 / `io_oeb` 1111 immediately. After release, the block stays in IDLE until `start`.
